// File: rtl/mul_cell_sched_pkg.sv
// Shared types and helpers for the 32x32 multiplier scheduler built around
// the registered three-partial-product 16x16 cell.
package mul_cell_sched_pkg;

   localparam int PART_W = 50;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      ISS_LO,
      CAP_LO,
      CAP_HI,
      RESP
   } state_t;

   // Turns the unsigned high word into the signed variants by subtracting
   // the cross terms contributed by negative operands (mod 2^32).
   function automatic logic [31:0] hi_word(input op_t op, input logic [31:0] hu,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] corr_a;
      logic [31:0] corr_b;
      corr_a = a[31] ? b : 32'h0;
      corr_b = b[31] ? a : 32'h0;
      case (op)
         OP_MULH:   hi_word = hu - corr_a - corr_b;
         OP_MULHSU: hi_word = hu - corr_a;
         default:   hi_word = hu;
      endcase
   endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// Two-way arbiter: round-robin on ties when RR_EN is set, otherwise
// requester 0 always wins. The pointer remembers the last granted id.
module mul_rr_arb #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic       grant_valid,
   output logic       grant_id
);

   logic ptr_reg;

   always_comb begin
      grant_valid = |valid;
      if (valid == 2'b11)
         grant_id = RR_EN ? ~ptr_reg : 1'b0;
      else
         grant_id = valid[1];
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset)
         ptr_reg <= 1'b1;
      else if (accept)
         ptr_reg <= grant_id;
   end

endmodule

// File: rtl/mul_cell_sched.sv
// Sequences the 16x16 three-partial-product cell into 32x32 MUL/MULH/MULHSU/MULHU
// results for two requesters sharing one tagged response port.
module mul_cell_sched
   import mul_cell_sched_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [1:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [1:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);

   state_t            state;
   op_t               op_reg;
   logic [31:0]       a_reg;
   logic [31:0]       b_reg;
   logic              id_reg;
   logic [PART_W-1:0] t_reg;

   logic              grant_valid;
   logic              grant_id;
   logic              accept;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;
   op_t               sel_op;
   logic [32:0]       mid_sum;
   logic [PART_W-1:0] t_next;
   logic [63:0]       hi_sum;

   mul_rr_arb #(.RR_EN(RR_EN)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .valid       ({req1_valid, req0_valid}),
      .accept      (accept),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign req0_ready = (state == IDLE) && !reset && grant_valid && !grant_id;
   assign req1_ready = (state == IDLE) && !reset && grant_valid && grant_id;
   assign accept     = req0_ready || req1_ready;

   assign sel_a  = grant_id ? req1_a : req0_a;
   assign sel_b  = grant_id ? req1_b : req0_b;
   assign sel_op = op_t'(grant_id ? req1_op : req0_op);

   // Low pass: the cell's cross products land at bit 16, the carry of their sum included.
   assign mid_sum = {1'b0, cell_p2} + {1'b0, cell_p3};
   assign t_next  = PART_W'(cell_p1) + (PART_W'(mid_sum) << 16);
   // High pass: cell_p1 now holds a[31:16]*b[31:16].
   assign hi_sum  = 64'(t_reg) + {cell_p1, 32'h0};

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_reg     <= OP_MUL;
         a_reg      <= 32'h0;
         b_reg      <= 32'h0;
         id_reg     <= 1'b0;
         t_reg      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= 32'h0;
         cell_src1  <= 32'h0;
         cell_src2  <= 32'h0;
         cell_en    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_reg    <= sel_op;
                  a_reg     <= sel_a;
                  b_reg     <= sel_b;
                  id_reg    <= grant_id;
                  cell_src1 <= sel_a;
                  cell_src2 <= sel_b;
                  cell_en   <= 1'b1;
                  state     <= ISS_LO;
               end
            end
            ISS_LO: begin
               // The high-half issue overlaps the low capture; the cell's outputs
               // are consumed at the same edge they are overwritten.
               if (op_reg != OP_MUL) begin
                  cell_src1 <= {16'h0, a_reg[31:16]};
                  cell_src2 <= {16'h0, b_reg[31:16]};
                  cell_en   <= 1'b1;
               end else begin
                  cell_en   <= 1'b0;
               end
               state <= CAP_LO;
            end
            CAP_LO: begin
               t_reg   <= t_next;
               cell_en <= 1'b0;
               if (op_reg == OP_MUL) begin
                  rsp_result <= t_next[31:0];
                  rsp_id     <= id_reg;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  state      <= CAP_HI;
               end
            end
            CAP_HI: begin
               rsp_result <= hi_word(op_reg, hi_sum[63:32], a_reg, b_reg);
               rsp_id     <= id_reg;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_cell_sched.sv
// Directed bench for mul_cell_sched: a round-robin and a fixed-priority instance
// share stimulus, each with its own behavioural 16x16 cell.
module tb_mul_cell_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_ready;

   logic        req0_ready, req1_ready, rsp_valid, rsp_id, cell_en;
   logic [31:0] rsp_result, cell_src1, cell_src2, cell_p1, cell_p2, cell_p3;

   logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_cell_en;
   logic [31:0] fp_rsp_result, fp_cell_src1, fp_cell_src2, fp_cell_p1, fp_cell_p2, fp_cell_p3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_cell_sched #(.RR_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
      .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
   );

   mul_cell_sched #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result),
      .cell_src1(fp_cell_src1), .cell_src2(fp_cell_src2), .cell_en(fp_cell_en),
      .cell_p1(fp_cell_p1), .cell_p2(fp_cell_p2), .cell_p3(fp_cell_p3)
   );

   // Behavioural multiplier cells: products registered on enabled edges.
   always @(posedge clk) begin
      if (cell_en) begin
         cell_p1 <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
         cell_p2 <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
         cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
      end
      if (fp_cell_en) begin
         fp_cell_p1 <= 32'(fp_cell_src1[15:0]) * 32'(fp_cell_src2[15:0]);
         fp_cell_p2 <= 32'(fp_cell_src1[15:0]) * 32'(fp_cell_src2[31:16]);
         fp_cell_p3 <= 32'(fp_cell_src1[31:16]) * 32'(fp_cell_src2[15:0]);
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at a falling edge with the DUT idle.
   task automatic run_op(input logic id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input logic tie);
      int n;
      if (id) begin
         req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; req0_valid = tie;
      end else begin
         req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; req1_valid = tie;
      end
      #1;
      check_value("grant", 32'(id ? req1_ready : req0_ready), 32'd1);
      check_value("other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check_value("iss_en", 32'(cell_en), 32'd1);
            check_value("iss_src1", cell_src1, a);
            check_value("iss_src2", cell_src2, b);
         end
         if (n == 2) begin
            check_value("cap_en", 32'(cell_en), 32'(op != 2'b00));
            check_value("cap_src1", cell_src1, (op == 2'b00) ? a : {16'h0, a[31:16]});
         end
      end while (!rsp_valid && n < 12);
      check_value("latency", 32'(n), 32'(exp_lat));
      check_value("result", rsp_result, exp_res);
      check_value("rsp_id", 32'(rsp_id), 32'(id));
      check_value("rsp_en", 32'(cell_en), 32'd0);
      $display("xact id=%0d op=%0d a=%h b=%h result=%h lat=%0d", id, op, a, b, rsp_result, n);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check_value("post_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rr_ids[4];
      int rr_cyc[4];
      int fp_ids[3];
      int rr_cnt, fp_cnt, n, stray;

      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = 2'b00; req1_op = 2'b00;
      req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_value("rst_valid", 32'(rsp_valid), 32'd0);
      check_value("rst_result", rsp_result, 32'h0);
      check_value("rst_id", 32'(rsp_id), 32'd0);
      check_value("rst_en", 32'(cell_en), 32'd0);
      check_value("rst_src1", cell_src1, 32'h0);
      check_value("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);

      run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1'b0);
      run_op(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 1'b0);
      run_op(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4, 1'b0);
      run_op(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4, 1'b0);
      run_op(1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 4, 1'b0);

      // Both requesters valid every cycle, responses always accepted.
      for (int i = 0; i < 4; i++) begin rr_ids[i] = -1; rr_cyc[i] = -1; end
      for (int i = 0; i < 3; i++) fp_ids[i] = -1;
      rr_cnt = 0; fp_cnt = 0;
      req0_op = 2'b00; req0_a = 32'd3; req0_b = 32'd5;
      req1_op = 2'b00; req1_a = 32'd7; req1_b = 32'd6;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         #1;
         if ((req0_ready || req1_ready) && rr_cnt < 4) begin
            rr_ids[rr_cnt] = int'(req1_ready);
            rr_cyc[rr_cnt] = c;
            rr_cnt++;
         end
         if ((fp_req0_ready || fp_req1_ready) && fp_cnt < 3) begin
            fp_ids[fp_cnt] = int'(fp_req1_ready);
            fp_cnt++;
         end
         if (rsp_valid) check_value("arb_result", rsp_result, rsp_id ? 32'd42 : 32'd15);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (6) @(negedge clk);
      rsp_ready = 1'b0;
      check_value("rr_g0", 32'(rr_ids[0]), 32'd0);
      check_value("rr_g1", 32'(rr_ids[1]), 32'd1);
      check_value("rr_g2", 32'(rr_ids[2]), 32'd0);
      check_value("rr_g3", 32'(rr_ids[3]), 32'd1);
      check_value("rr_period", 32'(rr_cyc[3] - rr_cyc[2]), 32'd4);
      check_value("fp_g0", 32'(fp_ids[0]), 32'd0);
      check_value("fp_g1", 32'(fp_ids[1]), 32'd0);
      check_value("fp_g2", 32'(fp_ids[2]), 32'd0);
      $display("xact arb rr=%0d%0d%0d%0d fp=%0d%0d%0d", rr_ids[0], rr_ids[1], rr_ids[2], rr_ids[3],
               fp_ids[0], fp_ids[1], fp_ids[2]);

      // Backpressure: MULHU 0x10000 * 0x30000 = 3 << 32, held for 10 cycles.
      req0_op = 2'b11; req0_a = 32'h0001_0000; req0_b = 32'h0003_0000; req0_valid = 1'b1;
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 12);
      check_value("bp_latency", 32'(n), 32'd4);
      req1_op = 2'b00; req1_a = 32'd2; req1_b = 32'd2; req1_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         check_value("bp_valid", 32'(rsp_valid), 32'd1);
         check_value("bp_result", rsp_result, 32'd3);
         check_value("bp_id", 32'(rsp_id), 32'd0);
         check_value("bp_ready", 32'({req1_ready, req0_ready}), 32'd0);
         check_value("bp_en", 32'(cell_en), 32'd0);
         @(negedge clk);
      end
      $display("xact backpressure result=%h id=%0d", rsp_result, rsp_id);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check_value("bp_rel_valid", 32'(rsp_valid), 32'd0);
      check_value("bp_rel_accept", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 12);
      check_value("bp2_latency", 32'(n), 32'd3);
      check_value("bp2_result", rsp_result, 32'd4);
      check_value("bp2_id", 32'(rsp_id), 32'd1);
      $display("xact id=1 op=0 a=2 b=2 result=%h lat=%0d", rsp_result, n);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);

      // Reset during CAP_HI drops the operation.
      req0_op = 2'b01; req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_valid = 1'b1;
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_value("rr_valid", 32'(rsp_valid), 32'd0);
      check_value("rr_result", rsp_result, 32'h0);
      check_value("rr_id", 32'(rsp_id), 32'd0);
      check_value("rr_en", 32'(cell_en), 32'd0);
      check_value("rr_src", cell_src1 | cell_src2, 32'h0);
      check_value("rr_ready", 32'({req1_ready, req0_ready}), 32'd0);
      rsp_ready = 1'b1;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) stray++;
      end
      rsp_ready = 1'b0;
      check_value("rr_no_rsp", 32'(stray), 32'd0);
      $display("xact reset_drop stray=%0d", stray);
      req1_op = 2'b00; req1_a = 32'd9; req1_b = 32'd9;
      run_op(1'b0, 2'b00, 32'd3, 32'd5, 32'd15, 3, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
